// File: rtl/clock_divider_prog.sv
// clock_divider_prog: N_CH independent programmable clock dividers sharing a
// single clock, a global phase-realign strobe and one configuration bus.
//
// Ports:
//   clk_in        - clock; all state updates on its rising edge
//   reset         - asynchronous, active-high reset
//   enable        - per-channel run enable
//   sync          - one-cycle strobe forcing every enabled channel to a period boundary
//   cfg_valid     - configuration write strobe
//   cfg_ch        - target channel of the write
//   cfg_period_m1 - new period minus one
//   cfg_high      - new high-phase length in cycles
//   clk_out       - registered divided clock per channel
//   tick          - registered one-cycle pulse on the first cycle of each period
//   pending       - shadow configuration written but not yet active
//   cfg_err       - registered one-cycle pulse on a write to a nonexistent channel
module clock_divider_prog #(
  parameter int N_CH              = 4,
  parameter int DIV_WIDTH         = 16,
  parameter int DEFAULT_PERIOD_M1 = 15,
  parameter int DEFAULT_HIGH      = 8,
  localparam int CH_W             = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [N_CH-1:0]      enable,
  input  logic                 sync,
  input  logic                 cfg_valid,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_period_m1,
  input  logic [DIV_WIDTH:0]   cfg_high,
  output logic [N_CH-1:0]      clk_out,
  output logic [N_CH-1:0]      tick,
  output logic [N_CH-1:0]      pending,
  output logic                 cfg_err
);

  localparam int HW = DIV_WIDTH + 1;
  localparam logic [DIV_WIDTH-1:0] DEF_PM1  = DIV_WIDTH'(DEFAULT_PERIOD_M1);
  localparam logic [HW-1:0]        DEF_HIGH = HW'(DEFAULT_HIGH);

  logic cfg_in_range;
  assign cfg_in_range = 32'(cfg_ch) < 32'(N_CH);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_valid && !cfg_in_range;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] act_pm1, sh_pm1, cnt, cnt_nx;
    logic [HW-1:0]        act_high, sh_high, eff_high;
    logic                 pend, clk_q, tick_q, wr, bnd;

    assign wr = cfg_valid && cfg_in_range && (cfg_ch == CH_W'(g));

    // A boundary that promotes the shadow must already compare against the
    // promoted high length, so the high length is selected before registering.
    always_comb begin
      cnt_nx   = ((cnt == act_pm1) || sync) ? '0 : cnt + DIV_WIDTH'(1);
      bnd      = enable[g] && (cnt_nx == '0);
      eff_high = (bnd && pend) ? sh_high : act_high;
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        act_pm1  <= DEF_PM1;
        act_high <= DEF_HIGH;
        sh_pm1   <= DEF_PM1;
        sh_high  <= DEF_HIGH;
        cnt      <= DEF_PM1;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else if (!enable[g]) begin
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        // Parking cnt at period_m1 makes the first enabled edge wrap to 0.
        if (wr) begin
          act_pm1  <= cfg_period_m1;
          act_high <= cfg_high;
          sh_pm1   <= cfg_period_m1;
          sh_high  <= cfg_high;
          pend     <= 1'b0;
          cnt      <= cfg_period_m1;
        end else begin
          cnt <= act_pm1;
        end
      end else begin
        cnt    <= cnt_nx;
        tick_q <= bnd;
        clk_q  <= {1'b0, cnt_nx} < eff_high;
        if (bnd && pend) begin
          act_pm1  <= sh_pm1;
          act_high <= sh_high;
        end
        // A write landing on a boundary is held for the following boundary.
        if (wr) begin
          sh_pm1  <= cfg_period_m1;
          sh_high <= cfg_high;
          pend    <= 1'b1;
        end else if (bnd) begin
          pend <= 1'b0;
        end
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend;
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;
  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int CW  = 3;

  logic           clk_in = 1'b0;
  logic           reset;
  logic [NCH-1:0] enable;
  logic           sync, cfg_valid;
  logic [CW-1:0]  cfg_ch;
  logic [DW-1:0]  cfg_period_m1;
  logic [DW:0]    cfg_high;
  logic [NCH-1:0] clk_out, tick, pending;
  logic           cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  clock_divider_prog #(
    .N_CH(NCH),
    .DIV_WIDTH(DW),
    .DEFAULT_PERIOD_M1(15),
    .DEFAULT_HIGH(8)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .sync(sync),
    .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch),
    .cfg_period_m1(cfg_period_m1),
    .cfg_high(cfg_high),
    .clk_out(clk_out),
    .tick(tick),
    .pending(pending),
    .cfg_err(cfg_err)
  );

  // Reference model: each channel tracks its period length, high length and
  // position within the period as plain integers.
  int m_per[NCH], m_high[NCH], m_sper[NCH], m_shigh[NCH], m_pos[NCH];
  bit m_pend[NCH], m_clk[NCH], m_tick[NCH];
  bit m_err;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_per[i] = 16; m_high[i] = 8; m_sper[i] = 16; m_shigh[i] = 8;
      m_pos[i] = 15; m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
    m_err = 0;
  endfunction

  function automatic void model_step();
    bit ok, wr;
    ok    = cfg_valid && (int'(cfg_ch) < NCH);
    m_err = cfg_valid && (int'(cfg_ch) >= NCH);
    for (int i = 0; i < NCH; i++) begin
      wr = ok && (int'(cfg_ch) == i);
      if (!enable[i]) begin
        if (wr) begin
          m_per[i] = int'(cfg_period_m1) + 1; m_high[i] = int'(cfg_high);
          m_sper[i] = m_per[i]; m_shigh[i] = m_high[i]; m_pend[i] = 0;
        end
        m_pos[i] = m_per[i] - 1; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        m_pos[i] = (m_pos[i] == m_per[i] - 1 || sync) ? 0 : m_pos[i] + 1;
        if (m_pos[i] == 0 && m_pend[i]) begin
          m_per[i] = m_sper[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
        end
        if (wr) begin
          m_sper[i] = int'(cfg_period_m1) + 1; m_shigh[i] = int'(cfg_high); m_pend[i] = 1;
        end
        m_clk[i]  = m_pos[i] < m_high[i];
        m_tick[i] = m_pos[i] == 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] ec, et, ep;
    @(posedge clk_in);
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_clk[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
    end
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("tick", 32'(tick), 32'(et));
    chk("pending", 32'(pending), 32'(ep));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic wr(input int ch, input int pm1, input int hi);
    cfg_valid = 1; cfg_ch = CW'(ch); cfg_period_m1 = DW'(pm1); cfg_high = (DW+1)'(hi);
    cycle();
    cfg_valid = 0;
  endtask

  task automatic wait_tick(input int ch, input string name);
    int n;
    n = 0;
    while (!tick[ch] && n < 200) begin cycle(); n++; end
    if (n >= 200) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  // Called on a tick cycle: measures the following period and its high count.
  task automatic measure(input int ch, output int p, output int h);
    p = 1; h = int'(clk_out[ch]);
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (tick[ch]) return;
      p++; h += int'(clk_out[ch]);
    end
    p = -1;
  endtask

  typedef struct {
    int ch; int pm1; int hi; int exp_per; int exp_high;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p, h, t, hc;
    vecs[0] = '{1, 4, 2, 5, 2};
    vecs[1] = '{2, 15, 0, 16, 0};
    vecs[2] = '{2, 15, 17, 16, 16};
    vecs[3] = '{3, 2, 1, 3, 1};
    vecs[4] = '{3, 0, 1, 1, 1};
    vecs[5] = '{4, 0, 0, 1, 0};
    vecs[6] = '{4, 6, 7, 7, 7};
    vecs[7] = '{1, 15, 8, 16, 8};

    reset = 1; enable = '0; sync = 0; cfg_valid = 0; cfg_ch = '0;
    cfg_period_m1 = '0; cfg_high = '0;
    model_reset();
    #12;
    chk("rst_clk_out", 32'(clk_out), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_pending", 32'(pending), 32'(0));
    chk("rst_cfg_err", 32'(cfg_err), 32'(0));

    // Default waveform on channel 0.
    enable = 5'b00001;
    @(negedge clk_in); reset = 0;
    cycle();
    chk("first_tick0", 32'(tick[0]), 32'(1));
    chk("first_clk0", 32'(clk_out[0]), 32'(1));
    t = 0; hc = 0;
    for (int n = 0; n < 32; n++) begin
      cycle(); t += int'(tick[0]); hc += int'(clk_out[0]);
    end
    chk("dflt_ticks", 32'(t), 32'(2));
    chk("dflt_highs", 32'(hc), 32'(16));

    // Table: program a disabled channel, enable it, measure one period.
    foreach (vecs[k]) begin
      enable[vecs[k].ch] = 0;
      cycle();
      wr(vecs[k].ch, vecs[k].pm1, vecs[k].hi);
      chk("dis_wr_pending", 32'(pending[vecs[k].ch]), 32'(0));
      enable[vecs[k].ch] = 1;
      cycle();
      chk("en_first_tick", 32'(tick[vecs[k].ch]), 32'(1));
      measure(vecs[k].ch, p, h);
      chk("tbl_period", 32'(p), 32'(vecs[k].exp_per));
      chk("tbl_high", 32'(h), 32'(vecs[k].exp_high));
    end

    // Periods 16,5,7,3 then a sync pulse.
    enable = '0; cycle();
    wr(0, 15, 8); wr(1, 4, 2); wr(2, 6, 3); wr(3, 2, 1);
    enable = 5'b01111;
    repeat (20) cycle();
    sync = 1; cycle(); sync = 0;
    chk("sync_all_tick", 32'(tick[3:0]), 32'(4'hf));
    repeat (30) cycle();

    // Enabled write mid-period: pending until the next boundary.
    wait_tick(1, "ch1");
    cycle();
    wr(1, 6, 3);
    chk("mid_wr_pending", 32'(pending[1]), 32'(1));
    wait_tick(1, "ch1b");
    chk("pend_clear_at_tick", 32'(pending[1]), 32'(0));
    measure(1, p, h);
    chk("new_period1", 32'(p), 32'(7));
    chk("new_high1", 32'(h), 32'(3));

    // Write landing on a boundary applies one period later.
    wait_tick(3, "ch3");
    cycle(); cycle();
    wr(3, 4, 2);
    chk("bnd_wr_tick", 32'(tick[3]), 32'(1));
    chk("bnd_wr_pending", 32'(pending[3]), 32'(1));
    measure(3, p, h);
    chk("bnd_old_period", 32'(p), 32'(3));
    measure(3, p, h);
    chk("bnd_new_period", 32'(p), 32'(5));

    // Out-of-range channel write.
    wr(5, 3, 1);
    chk("cfg_err_pulse", 32'(cfg_err), 32'(1));
    cycle();
    chk("cfg_err_clear", 32'(cfg_err), 32'(0));
    wr(7, 0, 0);
    repeat (10) cycle();

    // Asynchronous reset mid-high-phase with a pending write.
    wr(1, 9, 4);
    wait_tick(0, "ch0");
    cycle();
    @(negedge clk_in); #1 reset = 1;
    #1;
    chk("async_clk_out", 32'(clk_out), 32'(0));
    chk("async_pending", 32'(pending), 32'(0));
    chk("async_tick", 32'(tick), 32'(0));
    model_reset();
    @(negedge clk_in); reset = 0;
    cycle();
    chk("post_rst_tick", 32'(tick[3:0]), 32'(4'hf));
    measure(1, p, h);
    chk("post_rst_period", 32'(p), 32'(16));
    chk("post_rst_high", 32'(h), 32'(8));

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(31) == 0) enable[i] = ~enable[i];
      sync      = ($urandom_range(39) == 0);
      cfg_valid = ($urandom_range(5) == 0);
      cfg_ch    = CW'($urandom_range(7));
      cfg_period_m1 = DW'($urandom_range(20));
      cfg_high  = (DW+1)'($urandom_range(23));
      cycle();
    end
    sync = 0; cfg_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
